// File: rtl/pll_pkg.sv
// Shared types and helpers for the PFD loop filter: FSM states, PFD error encoding
// and a width-generic signed saturating add.
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lf_state_t;

  typedef logic signed [1:0] err_t;

  localparam err_t ERR_ZERO = 2'sb00;
  localparam err_t ERR_POS  = 2'sb01;
  localparam err_t ERR_NEG  = 2'sb11;

  localparam int SAT_MAX_W = 32;

  // Operands are sign-extended to SAT_MAX_W; the result is clamped to a w-bit signed range.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int                          w
  );
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sum = $signed({a[SAT_MAX_W-1], a}) + $signed({b[SAT_MAX_W-1], b});
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) return hi[SAT_MAX_W-1:0];
    if (sum < lo) return lo[SAT_MAX_W-1:0];
    return sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/pll_lock_det.sv
// Lock detector: counts quiet updates while acquiring and same-sign error runs while
// locked, and pulses go_lock / go_unlock on the update that reaches the threshold.
module pll_lock_det
  import pll_pkg::*;
#(
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic upd,
  input  logic in_acq,
  input  logic in_lock,
  input  err_t err,
  output logic go_lock,
  output logic go_unlock
);

  localparam int QW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(UNLOCK_CNT + 1);

  logic [QW-1:0] quiet_cnt, quiet_nxt;
  logic [RW-1:0] run_cnt, run_nxt;
  logic          last_neg;

  // Counters only advance on updates; a missing update (freeze) clears them.
  always_comb begin
    quiet_nxt = '0;
    run_nxt   = '0;
    if (upd && in_acq && err == ERR_ZERO) quiet_nxt = quiet_cnt + 1'b1;
    if (upd && in_lock && err != ERR_ZERO) begin
      if (run_cnt != '0 && err[1] == last_neg) run_nxt = run_cnt + 1'b1;
      else                                     run_nxt = RW'(1);
    end
    go_lock   = in_acq  && (quiet_nxt == QW'(LOCK_CNT));
    go_unlock = in_lock && (run_nxt   == RW'(UNLOCK_CNT));
  end

  always_ff @(posedge clk) begin
    if (rst || go_lock || go_unlock) begin
      quiet_cnt <= '0;
      run_cnt   <= '0;
    end else begin
      quiet_cnt <= quiet_nxt;
      run_cnt   <= run_nxt;
    end
    if (rst)                           last_neg <= 1'b0;
    else if (upd && err != ERR_ZERO)   last_neg <= err[1];
  end

endmodule

// File: rtl/pfd_loop_filter.sv
// PFD-driven saturating PI loop filter producing the DCO control word, with a
// gain-switching acquire/lock FSM.
module pfd_loop_filter
  import pll_pkg::*;
#(
  parameter int CTRL_W       = 10,
  parameter int ACC_W        = 16,
  parameter int CTRL_CENTER  = 512,
  parameter int KP_ACQ_SHIFT = 4,
  parameter int KP_TRK_SHIFT = 1,
  parameter int KI_SHIFT     = 4,
  parameter int LOCK_CNT     = 64,
  parameter int UNLOCK_CNT   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              dn,
  output logic [CTRL_W-1:0] ctrl,
  output logic              ctrl_vld,
  output logic              lock,
  output logic              acq
);

  localparam int KP_MAX = (KP_ACQ_SHIFT > KP_TRK_SHIFT) ? KP_ACQ_SHIFT : KP_TRK_SHIFT;
  localparam int SUM_W  = ((ACC_W > CTRL_W + KP_MAX) ? ACC_W : CTRL_W + KP_MAX) + 2;

  localparam logic signed [SUM_W-1:0] CENTER_S   = SUM_W'(CTRL_CENTER);
  localparam logic signed [SUM_W-1:0] CTRL_MAX_S = SUM_W'((1 << CTRL_W) - 1);

  function automatic logic [CTRL_W-1:0] clamp_ctrl(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1])      return '0;
    if (s > CTRL_MAX_S)  return '1;
    return s[CTRL_W-1:0];
  endfunction

  lf_state_t               state, state_nxt;
  err_t                    err_p0, err_p1;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic signed [SUM_W-1:0] prop, integ, sum;
  logic                    upd, go_lock, go_unlock;

  always_comb begin
    state_nxt = state;
    acq       = (state == ACQUIRE);
    if (!en) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = ACQUIRE;
        ACQUIRE: if (go_lock)   state_nxt = LOCKED;
        LOCKED:  if (go_unlock) state_nxt = ACQUIRE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0: decode PFD pulses; coincident up/dn is the PFD reset overlap, not an error.
  always_comb begin
    err_p0 = ERR_ZERO;
    if (up && !dn)      err_p0 = ERR_POS;
    else if (dn && !up) err_p0 = ERR_NEG;
  end

  // Stage p1: PI update from the registered error; gain follows the current state.
  assign upd   = (state != IDLE) && en;
  assign acc_n = ACC_W'(sat_add(SAT_MAX_W'(acc), SAT_MAX_W'(err_p1), ACC_W));
  assign prop  = SUM_W'(err_p1) <<< ((state == LOCKED) ? KP_TRK_SHIFT : KP_ACQ_SHIFT);
  assign integ = SUM_W'(acc_n >>> KI_SHIFT);
  assign sum   = CENTER_S + prop + integ;

  pll_lock_det #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT)
  ) u_lock_det (
    .clk      (clk),
    .rst      (rst),
    .upd      (upd),
    .in_acq   (state == ACQUIRE),
    .in_lock  (state == LOCKED),
    .err      (err_p1),
    .go_lock  (go_lock),
    .go_unlock(go_unlock)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      err_p1   <= ERR_ZERO;
      acc      <= '0;
      ctrl     <= CTRL_W'(CTRL_CENTER);
      ctrl_vld <= 1'b0;
      lock     <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_p1   <= err_p0;
      ctrl_vld <= upd;
      if (upd) begin
        acc  <= acc_n;
        ctrl <= clamp_ctrl(sum);
      end
      // Entering IDLE holds lock; any other state defines it.
      if (state_nxt != IDLE) lock <= (state_nxt == LOCKED);
    end
  end

endmodule
